// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the two-port SRAM arbiter: per-port command/handshake,
// shared read data and the memory-clear busy flag.
interface sram_arbiter_if #(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_WIDTH   = 8
);
  logic                    req0;
  logic                    we0;
  logic [ADDRESS_BITS-1:0] addr0;
  logic [DATA_WIDTH-1:0]   wdata0;
  logic                    ack0;
  logic                    rvalid0;
  logic                    req1;
  logic                    we1;
  logic [ADDRESS_BITS-1:0] addr1;
  logic [DATA_WIDTH-1:0]   wdata1;
  logic                    ack1;
  logic                    rvalid1;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    busy;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  ack0, rvalid0, ack1, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output ack0, rvalid0, ack1, rvalid1, rdata, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter owning a single-port SRAM: clears memory after reset, then
// serves one request at a time. Define SRAM_ARB_FIXED_PRI_EN for fixed port-0 priority.
module sram_arbiter #(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REG      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  sram_arbiter_if.slave           bus,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic                    mem_rd,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

  localparam int CNT_W = ADDRESS_BITS + 1;

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RDATA} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic                    rd_q, rd_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic                    ack0_q, ack0_d, ack1_q, ack1_d;
  logic                    rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;

  logic                    gnt_any, gnt_sel, init_done;

  assign init_done = (cnt_q == CNT_W'(NUM_REG));

  always_comb begin
    gnt_any = bus.req0 | bus.req1;
`ifdef SRAM_ARB_FIXED_PRI_EN
    gnt_sel = ~bus.req0;
`else
    gnt_sel = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b1;
      addr_q  <= '0;
      wdat_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_done) state_d = IDLE;
      IDLE:    if (gnt_any) state_d = ACCESS;
      ACCESS:  state_d = wr_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Registered outputs: ack/rvalid are single-cycle pulses, the rest hold.
  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    we_d    = we_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    case (state_q)
      INIT: begin
        if (init_done) begin
          cs_d   = 1'b0;
          we_d   = 1'b0;
          busy_d = 1'b0;
        end else begin
          cs_d   = 1'b1;
          we_d   = 1'b1;
          rd_d   = 1'b1;
          addr_d = cnt_q[ADDRESS_BITS-1:0];
          wdat_d = '0;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (gnt_any) begin
          cs_d   = 1'b1;
          we_d   = gnt_sel ? bus.we1 : bus.we0;
          rd_d   = gnt_sel ? bus.we1 : bus.we0;
          addr_d = gnt_sel ? bus.addr1 : bus.addr0;
          wdat_d = gnt_sel ? bus.wdata1 : bus.wdata0;
          ack0_d = ~gnt_sel;
          ack1_d = gnt_sel;
          last_d = gnt_sel;
          gnt_d  = gnt_sel;
          wr_d   = gnt_sel ? bus.we1 : bus.we0;
        end
      end
      ACCESS: begin
        cs_d = 1'b0;
        we_d = 1'b0;
        rd_d = 1'b1;
      end
      RDATA: begin
        rdata_d = mem_rd_data;
        rv0_d   = ~gnt_q;
        rv1_d   = gnt_q;
      end
      default: ;
    endcase
  end

  assign mem_cs      = cs_q;
  assign mem_we      = we_q;
  assign mem_rd      = rd_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdat_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.rvalid0 = rv0_q;
  assign bus.rvalid1 = rv1_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed init/handshake vectors plus
// randomized traffic checked against a transaction-level model.
module tb_sram_arbiter;

  localparam int AB = 5;
  localparam int DW = 8;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_cs, mem_we, mem_rd;
  logic [AB-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  sram_arbiter_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW)) bus ();

  sram_arbiter #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .NUM_REG(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Simple registered-read SRAM; filled with non-zero junk during reset.
  logic [DW-1:0] sram [NR];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) sram[i] <= 8'h80 | 8'(i);
    end else if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_wr_data;
      else if (!mem_rd) mem_rd_data <= sram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rst_vec();
    return {3'b0, mem_cs, mem_we, mem_rd, mem_addr, mem_wr_data,
            bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.rdata, bus.busy};
  endfunction
  localparam logic [31:0] RST_EXP = {3'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00,
                                     4'b0000, 8'h00, 1'b1};

  function automatic logic [31:0] init_vec();
    return {14'b0, mem_cs, mem_we, mem_rd, mem_addr, mem_wr_data, bus.busy, bus.ack1};
  endfunction

  task automatic drive(input logic r0, input logic w0, input logic [AB-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AB-1:0] a1, input logic [DW-1:0] d1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({name, "_busy_timeout"}, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic reset_and_wait();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    wait_idle("reinit");
  endtask

  typedef struct {
    logic          r0, w0;
    logic [AB-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AB-1:0] a1;
    logic [DW-1:0] d1;
    logic [4:0]    exp;   // {ack0, ack1, rvalid0, rvalid1, mem_we}
    logic          chk;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl [14];

  // Random-phase requester state and reference model.
  logic          rq [2];
  logic          wq [2];
  logic [AB-1:0] aq [2];
  logic [DW-1:0] dq [2];
  logic [DW-1:0] ref_mem [NR];

  task automatic new_cmd(input int p);
    rq[p] = 1'b1;
    wq[p] = 1'($urandom_range(0, 1));
    aq[p] = AB'($urandom_range(0, NR - 1));
    dq[p] = DW'($urandom_range(0, 255));
  endtask

  initial begin
    logic [31:0] ev;
    int   e, nxt_ok, rv_edge, rv_port, last, sel;
    logic can;
    logic [DW-1:0] rv_data;

    tbl[0]  = '{1'b1, 1'b1, 5'd3,  8'hA5, 1'b0, 1'b0, 5'd0,  8'h00, 5'b10001, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00000, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 5'd3,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b10000, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00000, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00100, 1'b1, 8'hA5};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00000, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd31, 8'h3C, 5'b01001, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00000, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd31, 8'h00, 5'b01000, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 5'd5,  8'h77, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00000, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 5'd5,  8'h77, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00010, 1'b1, 8'h3C};
    tbl[11] = '{1'b1, 1'b1, 5'd5,  8'h77, 1'b0, 1'b0, 5'd0,  8'h00, 5'b10001, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00000, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 5'b00000, 1'b0, 8'h00};

    // ---- Reset, memory clear, and a port-1 read requested during INIT ----
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    check("reset_values", rst_vec(), RST_EXP);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd7, '0);
    for (int k = 1; k <= NR + 1; k++) begin
      tick();
      if (k <= NR)
        ev = {14'b0, 1'b1, 1'b1, 1'b1, 5'(k - 1), 8'h00, 1'b1, 1'b0};
      else
        ev = {14'b0, 1'b0, 1'b0, 1'b1, 5'(NR - 1), 8'h00, 1'b0, 1'b0};
      check($sformatf("init_edge%0d", k), init_vec(), ev);
    end
    tick();
    check("init_req1_ack", {mem_rd, mem_addr, bus.ack1}, {1'b0, 5'd7, 1'b1});
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    check("init_read_access", {bus.ack1, bus.rvalid1}, 2'b00);
    tick();
    check("read_cleared_addr7", {bus.rvalid1, bus.rdata}, {1'b1, 8'h00});

    // ---- Table-driven single-port sequences ----
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      tick();
      check($sformatf("vec%0d_flags", i),
            {bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, mem_we}, tbl[i].exp);
      if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].erd);
    end

    // ---- Reset while in RDATA ----
    drive(1'b1, 1'b0, 5'd3, '0, 1'b0, 1'b0, '0, '0);
    tick();
    check("rdreset_ack0", bus.ack0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    reset = 1'b1;
    #1;
    check("rdreset_async", rst_vec(), RST_EXP);
    tick();
    check("rdreset_held", rst_vec(), RST_EXP);
    reset = 1'b0;
    tick();
    check("rdreset_init_restart",
          {mem_cs, mem_we, mem_addr, bus.busy, bus.rvalid0}, {1'b1, 1'b1, 5'd0, 1'b1, 1'b0});
    wait_idle("rdreset");

    // ---- Both ports writing continuously ----
    drive(1'b1, 1'b1, 5'd10, 8'h00, 1'b1, 1'b1, 5'd11, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 0) ev = 32'd0;
`ifdef SRAM_ARB_FIXED_PRI_EN
      else ev = 32'd2;
`else
      else ev = (k % 4 == 1) ? 32'd2 : 32'd1;
`endif
      check($sformatf("tie_edge%0d", k), {30'b0, bus.ack0, bus.ack1}, ev);
      if (bus.ack0) bus.wdata0 = bus.wdata0 + 8'd1;
      if (bus.ack1) bus.wdata1 = bus.wdata1 + 8'd1;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    tick();

    // ---- Randomized traffic vs transaction-level model ----
    reset_and_wait();
    for (int i = 0; i < NR; i++) ref_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wq[p] = 1'b0; aq[p] = '0; dq[p] = '0;
    end
    nxt_ok = 0; rv_edge = -1; rv_port = 0; rv_data = '0; last = 1;
    for (e = 1; e <= 1500; e++) begin
      for (int p = 0; p < 2; p++)
        if (!rq[p] && $urandom_range(0, 2) == 0) new_cmd(p);
      drive(rq[0], wq[0], aq[0], dq[0], rq[1], wq[1], aq[1], dq[1]);
      can = (e >= nxt_ok) && (rq[0] || rq[1]);
`ifdef SRAM_ARB_FIXED_PRI_EN
      sel = rq[0] ? 0 : 1;
`else
      sel = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
`endif
      tick();
      ev = {28'b0, can && sel == 0, can && sel == 1,
            e == rv_edge && rv_port == 0, e == rv_edge && rv_port == 1};
      check($sformatf("rand_e%0d", e),
            {28'b0, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1}, ev);
      if (e == rv_edge) check($sformatf("rand_rdata_e%0d", e), bus.rdata, rv_data);
      if (can) begin
        last = sel;
        if (wq[sel]) begin
          ref_mem[aq[sel]] = dq[sel];
          nxt_ok = e + 2;
        end else begin
          rv_edge = e + 2;
          rv_port = sel;
          rv_data = ref_mem[aq[sel]];
          nxt_ok  = e + 3;
        end
        if ($urandom_range(0, 1) == 0) rq[sel] = 1'b0;
        else new_cmd(sel);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port round-robin controller for the single-port `sram` (cs/we/active-low rd, registered read).
- Owns all SRAM control pins. After reset it clears the whole memory to zero, then grants one requester access at a time.
- Returns read data to the requester with a one-cycle valid strobe.
- Sits between two bus masters and one `sram` instance, whose pins connect directly to the mem_* ports.

Parameters:
- ADDRESS_BITS, 5, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- NUM_REG, 32, number of SRAM words cleared during init (≤ 2^ADDRESS_BITS).

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 request; held with command until ack0.
- we0  input  1  port 0: 1 = write, 0 = read.
- addr0  input  ADDRESS_BITS  port 0 address.
- wdata0  input  DATA_WIDTH  port 0 write data.
- ack0  output  1  one-cycle grant/accept pulse for port 0.
- rvalid0  output  1  one-cycle read-data-valid for port 0.
- req1, we1, addr1, wdata1, ack1, rvalid1: same as port 0, for port 1.
- rdata  output  DATA_WIDTH  read data; qualified by rvalid0/rvalid1.
- busy  output  1  high while the memory is being cleared.
- mem_cs  output  1  SRAM chip select.
- mem_we  output  1  SRAM write enable.
- mem_rd  output  1  SRAM read enable, active low.
- mem_addr  output  ADDRESS_BITS  SRAM address.
- mem_wr_data  output  DATA_WIDTH  SRAM write data.
- mem_rd_data  input  DATA_WIDTH  SRAM read data.

Behaviour:
- All outputs registered. FSM states: INIT, IDLE, ACCESS, RDATA.
- Reset values: mem_cs=0, mem_we=0, mem_rd=1, mem_addr=0, mem_wr_data=0, ack*=0, rvalid*=0, rdata=0, busy=1, state=INIT, init count=0, last_grant=1.
- INIT (memory clear):
  - Each edge issues one write: mem_cs=1, mem_we=1, mem_rd=1, mem_addr=count, mem_wr_data=0; count increments.
  - After the command for address NUM_REG-1 has been presented for one cycle, the next edge sets mem_cs=0, mem_we=0, busy=0 and moves to IDLE.
  - busy is high for NUM_REG+1 edges after reset release. Requests are ignored in INIT; no ack is given.
- IDLE: each edge samples req0/req1.
  - Single request: grant that port.
  - Both requesting: grant the port not equal to last_grant; last_grant is updated on every grant.
  - On grant (same edge): drive mem_cs=1, mem_we=weN, mem_rd=weN (low for read), mem_addr=addrN, mem_wr_data=wdataN; ackN=1; go to ACCESS.
- ACCESS: the SRAM acts on this edge.
  - Controller sets mem_cs=0, mem_we=0, mem_rd=1, ackN=0.
  - Write: go to IDLE.
  - Read: go to RDATA.
- RDATA: capture mem_rd_data into rdata, rvalidN=1 for one cycle, go to IDLE. rdata holds its value until the next read.
- Latency:
  - Write: granted at edge E, memory updated at E+1, next grant earliest E+2.
  - Read: granted at E, rvalid at E+2, next grant earliest E+3.
- Handshake:
  - Requester keeps reqN and its command stable until it sees ackN high.
  - It must drop reqN, or present a new command, by the edge ending the ack cycle.
  - req is not sampled in ACCESS/RDATA.
- Only one access is outstanding; the two ports never overlap.
- mem_addr and mem_wr_data hold their last values while mem_cs=0.
- Reset mid-operation forces reset values immediately; an in-flight read produces no rvalid, and the memory is cleared again.

Optional Feature:
- SRAM_ARB_FIXED_PRI_EN defined: fixed priority. Port 0 always wins simultaneous requests; last_grant is unused.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset release, no requests -> busy high for 33 edges, exactly 32 writes of 0 to addresses 0..31 in order, then mem_cs=0 and busy=0; a read of addr 7 returns 0x00.
- Port 0 writes 0xA5 to addr 3, then reads addr 3 -> ack0 on the grant edge, mem_we=1 for one cycle, rvalid0 with rdata=0xA5 two edges after the read grant.
- req0 and req1 held continuously, both doing writes -> grants alternate 0,1,0,1 (first tie goes to port 0), one grant every 2 cycles. With SRAM_ARB_FIXED_PRI_EN defined -> port 0 granted every time.
- Port 1 read of addr 31 while port 0 requests a write -> rvalid1 delivers the stored value, then port 0 is granted; rvalid0 never asserts.
- reset asserted while in RDATA -> no rvalid, all outputs at reset values, busy=1 and INIT restarts at address 0.
- req1 asserted during INIT -> no ack1 until busy=0; ack1 on the first IDLE edge.
